// File: rtl/rgs_rng_pkg.sv
// Shared types and defaults for the RNG health monitor: symbol width,
// window/cutoff defaults and the monitor state encoding.
package rgs_rng_pkg;

  localparam int SYM_W          = 2;
  localparam int WINDOW_DEF     = 64;
  localparam int APT_CUTOFF_DEF = 40;
  localparam int RCT_CUTOFF_DEF = 12;

  typedef enum logic [1:0] {
    STARTUP = 2'd0,
    RUN     = 2'd1,
    FAIL    = 2'd2
  } state_e;

endpackage

// File: rtl/rgs_rng_health_monitor_if.sv
// Symbol stream in, forwarded stream and health status out.
interface rgs_rng_health_monitor_if;
  import rgs_rng_pkg::*;

  logic             i_en;
  logic             i_valid;
  logic [SYM_W-1:0] i_r;
  logic             i_clear;
  logic             o_valid;
  logic [SYM_W-1:0] o_r;
  logic             o_healthy;
  logic             o_rct_fail;
  logic             o_apt_fail;

  modport master (
    output i_en, i_valid, i_r, i_clear,
    input  o_valid, o_r, o_healthy, o_rct_fail, o_apt_fail
  );

  modport slave (
    input  i_en, i_valid, i_r, i_clear,
    output o_valid, o_r, o_healthy, o_rct_fail, o_apt_fail
  );

endinterface

// File: rtl/rgs_sat_counter.sv
// Saturating up-counter with sync clear, load-to-1 and a flag that fires
// when the value about to be stored equals CUTOFF.
module rgs_sat_counter #(
  parameter int W      = 8,
  parameter int CUTOFF = 12
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic clr_i,
  input  logic en_i,
  input  logic load_i,
  output logic hit_o
);

  localparam logic [W-1:0] CUT = W'(CUTOFF);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      if (load_i) begin
        cnt_d = W'(1);
      end else if (cnt_q != CUT) begin
        cnt_d = cnt_q + W'(1);
      end
    end
  end

  assign hit_o = en_i & ~clr_i & (cnt_d == CUT);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/rgs_rng_health_monitor.sv
// Continuous RCT/APT health monitor on a random symbol stream; forwards
// symbols only after a clean startup window, latches failures until cleared.
module rgs_rng_health_monitor
  import rgs_rng_pkg::*;
#(
  parameter int WINDOW     = WINDOW_DEF,
  parameter int APT_CUTOFF = APT_CUTOFF_DEF,
  parameter int RCT_CUTOFF = RCT_CUTOFF_DEF
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  rgs_rng_health_monitor_if.slave  bus
);

  localparam int WIN_W = $clog2(WINDOW);
  localparam int RUN_W = $clog2(RCT_CUTOFF + 1);
  localparam int MAT_W = $clog2(APT_CUTOFF + 1);
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW - 1);

  state_e           state_q;
  logic [WIN_W-1:0] win_cnt_q;
  logic [SYM_W-1:0] last_q;
  logic [SYM_W-1:0] ref_q;
  logic [SYM_W-1:0] r_q;
  logic             valid_q;
  logic             healthy_q;
  logic             rct_fail_q;
  logic             apt_fail_q;

  logic acc;
  logic clr;
  logic win_first;
  logic win_wrap;
  logic rct_hit;
  logic apt_hit;
  logic fail_any;

  assign clr       = bus.i_clear;
  assign acc       = bus.i_en & bus.i_valid & ~bus.i_clear & (state_q != FAIL);
  assign win_first = (win_cnt_q == '0);
  assign win_wrap  = acc & (win_cnt_q == WIN_LAST);
  assign fail_any  = rct_hit | apt_hit;

  // A zero run increments to 1, so only a symbol change needs an explicit load.
  rgs_sat_counter #(
    .W      (RUN_W),
    .CUTOFF (RCT_CUTOFF)
  ) u_run (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .clr_i   (clr),
    .en_i    (acc),
    .load_i  (bus.i_r != last_q),
    .hit_o   (rct_hit)
  );

  rgs_sat_counter #(
    .W      (MAT_W),
    .CUTOFF (APT_CUTOFF)
  ) u_match (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .clr_i   (clr),
    .en_i    (acc & (win_first | (bus.i_r == ref_q))),
    .load_i  (win_first),
    .hit_o   (apt_hit)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= STARTUP;
      win_cnt_q  <= '0;
      last_q     <= '0;
      ref_q      <= '0;
      r_q        <= '0;
      valid_q    <= 1'b0;
      healthy_q  <= 1'b0;
      rct_fail_q <= 1'b0;
      apt_fail_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (clr) begin
        // last_q deliberately survives a clear; run restarts at 0 anyway.
        state_q    <= STARTUP;
        win_cnt_q  <= '0;
        ref_q      <= '0;
        healthy_q  <= 1'b0;
        rct_fail_q <= 1'b0;
        apt_fail_q <= 1'b0;
      end else if (acc) begin
        last_q    <= bus.i_r;
        win_cnt_q <= win_wrap ? '0 : win_cnt_q + WIN_W'(1);
        if (win_first) ref_q <= bus.i_r;
        if (rct_hit) rct_fail_q <= 1'b1;
        if (apt_hit) apt_fail_q <= 1'b1;
        case (state_q)
          STARTUP: begin
            if (fail_any) begin
              state_q <= FAIL;
            end else if (win_wrap) begin
              state_q   <= RUN;
              healthy_q <= 1'b1;
            end
          end
          RUN: begin
            if (fail_any) begin
              state_q   <= FAIL;
              healthy_q <= 1'b0;
            end else begin
              valid_q <= 1'b1;
              r_q     <= bus.i_r;
            end
          end
          default: begin
            state_q <= FAIL;
          end
        endcase
      end
    end
  end

  assign bus.o_valid    = valid_q;
  assign bus.o_r        = r_q;
  assign bus.o_healthy  = healthy_q;
  assign bus.o_rct_fail = rct_fail_q;
  assign bus.o_apt_fail = apt_fail_q;

endmodule
